// File: rtl/async_pkg.sv
// Shared types and default parameters for the async_seq input front end.
package async_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } seq_state_t;

  localparam int ASYNC_SYNC_STAGES = 2;
  localparam int ASYNC_DEBOUNCE    = 4;
  localparam int ASYNC_SETTLE      = 3;

endpackage

// File: rtl/sync_debounce.sv
// One input channel: flop-chain synchronizer followed by a saturating debounce
// counter measured against the currently committed output value.
module sync_debounce
  import async_pkg::*;
#(
  parameter int SYNC_STAGES = ASYNC_SYNC_STAGES,
  parameter int DEBOUNCE    = ASYNC_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic committed,
  output logic pending
);

  localparam int              CW   = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]   CMAX = CW'(DEBOUNCE);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_count;
  logic                   r_pending;
  logic                   w_sync;
  logic                   w_differs;

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_differs = (w_sync != committed);
  assign pending   = r_pending;

  // Only r_sync[0] samples the asynchronous raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
    end
  end

  // Pending is registered, and gated by the live comparison so a withdrawn or
  // just-committed change never presents a stale request to the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (!w_differs) begin
        r_count <= '0;
      end else if (r_count != CMAX) begin
        r_count <= r_count + CW'(1);
      end
      r_pending <= (r_count == CMAX) && w_differs;
    end
  end

endmodule

// File: rtl/async_input_sequencer.sv
// Front end for async_seq: applies at most one debounced input change at a time,
// then holds off further changes for a settle gap. Channel 1 wins ties.
module async_input_sequencer #(
  parameter int SYNC_STAGES = async_pkg::ASYNC_SYNC_STAGES,
  parameter int DEBOUNCE    = async_pkg::ASYNC_DEBOUNCE,
  parameter int SETTLE      = async_pkg::ASYNC_SETTLE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   x1_raw,
  input  logic                   x2_raw,
  output logic                   x1,
  output logic                   x2,
  output logic                   busy,
  output logic                   conflict,
  output async_pkg::seq_state_t  dbg_state
);

  import async_pkg::*;

  localparam int            SW    = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SLOAD = SW'(SETTLE);

  seq_state_t    r_state;
  seq_state_t    w_state_nxt;
  logic [SW-1:0] r_settle;
  logic [SW-1:0] w_settle_nxt;
  logic          r_x1;
  logic          r_x2;
  logic          r_conflict;
  logic          w_x1_nxt;
  logic          w_x2_nxt;
  logic          w_conflict_nxt;
  logic          w_pend1;
  logic          w_pend2;

  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_ch1 (
    .clk(clk), .rst(rst), .raw(x1_raw), .committed(r_x1), .pending(w_pend1)
  );

  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_ch2 (
    .clk(clk), .rst(rst), .raw(x2_raw), .committed(r_x2), .pending(w_pend2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= async_pkg::IDLE;
      r_settle   <= '0;
      r_x1       <= 1'b0;
      r_x2       <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_settle   <= w_settle_nxt;
      r_x1       <= w_x1_nxt;
      r_x2       <= w_x2_nxt;
      r_conflict <= w_conflict_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_settle_nxt   = r_settle;
    w_x1_nxt       = r_x1;
    w_x2_nxt       = r_x2;
    w_conflict_nxt = 1'b0;
    case (r_state)
      async_pkg::IDLE: begin
        if (w_pend1) begin
          w_x1_nxt       = ~r_x1;
          w_conflict_nxt = w_pend2;
          w_state_nxt    = async_pkg::SETTLE;
          w_settle_nxt   = SLOAD;
        end else if (w_pend2) begin
          w_x2_nxt     = ~r_x2;
          w_state_nxt  = async_pkg::SETTLE;
          w_settle_nxt = SLOAD;
        end
      end
      async_pkg::SETTLE: begin
        // The toggling edge is the first busy cycle, so leave on the count of 1.
        if (r_settle <= SW'(1)) begin
          w_state_nxt  = async_pkg::IDLE;
          w_settle_nxt = '0;
        end else begin
          w_settle_nxt = r_settle - SW'(1);
        end
      end
      default: begin
        w_state_nxt  = async_pkg::IDLE;
        w_settle_nxt = '0;
      end
    endcase
  end

  assign x1        = r_x1;
  assign x2        = r_x2;
  assign conflict  = r_conflict;
  assign busy      = (r_state == async_pkg::SETTLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_async_input_sequencer.sv
// Bench for async_input_sequencer: output-change scoreboard keyed by edge number,
// plus per-scenario inline checks of busy/conflict/output levels.
module tb_async_input_sequencer;
  import async_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x1_raw = 1'b0;
  logic       x2_raw = 1'b0;
  logic       x1;
  logic       x2;
  logic       busy;
  logic       conflict;
  seq_state_t dbg_state;

  logic [31:0] cyc = '0;
  logic        prev_x1 = 1'b0;
  logic        prev_x2 = 1'b0;
  logic [33:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  async_input_sequencer dut (
    .clk(clk), .rst(rst), .x1_raw(x1_raw), .x2_raw(x2_raw),
    .x1(x1), .x2(x2), .busy(busy), .conflict(conflict), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Scoreboard: each output change is checked against the next expected {edge, x1, x2}.
  always begin
    logic [33:0] obs;
    logic [33:0] e;
    @(posedge clk);
    cyc++;
    #1;
    if (rst) begin
      prev_x1 = x1;
      prev_x2 = x2;
    end else if (x1 !== prev_x1 || x2 !== prev_x2) begin
      obs = {cyc, x1, x2};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: change at edge %0d to x1=%0b x2=%0b, expected no change",
                 cyc, x1, x2);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_err++;
          $display("FAIL sb_change: got edge %0d x1=%0b x2=%0b, expected edge %0d x1=%0b x2=%0b",
                   obs[33:2], obs[1], obs[0], e[33:2], e[1], e[0]);
        end
      end
      prev_x1 = x1;
      prev_x2 = x2;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({x1, x2, busy, conflict} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs: got %4b expected 0000", {x1, x2, busy, conflict});
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d expected IDLE", dbg_state);
    end
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_change();
    int   base;
    int   e;
    logic exp_busy;
    x1_raw = 1'b1;
    base = int'(cyc) + 1;
    exp_q.push_back({32'(base + 7), 1'b1, 1'b0});
    for (int i = 0; i < 12; i++) begin
      step();
      e = int'(cyc) - base;
      exp_busy = (e >= 7 && e <= 9);
      n_cmp++;
      if (busy !== exp_busy) begin
        n_err++;
        $display("FAIL single_rise_busy: edge %0d busy=%0b expected %0b", e, busy, exp_busy);
      end
      n_cmp++;
      if (x1 !== (e >= 7)) begin
        n_err++;
        $display("FAIL single_rise_x1: edge %0d x1=%0b expected %0b", e, x1, (e >= 7));
      end
    end
    x1_raw = 1'b0;
    base = int'(cyc) + 1;
    exp_q.push_back({32'(base + 7), 1'b0, 1'b0});
    for (int i = 0; i < 12; i++) begin
      step();
      e = int'(cyc) - base;
      exp_busy = (e >= 7 && e <= 9);
      n_cmp++;
      if (busy !== exp_busy) begin
        n_err++;
        $display("FAIL single_fall_busy: edge %0d busy=%0b expected %0b", e, busy, exp_busy);
      end
      n_cmp++;
      if (x1 !== (e < 7)) begin
        n_err++;
        $display("FAIL single_fall_x1: edge %0d x1=%0b expected %0b", e, x1, (e < 7));
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL single_missing: %0d changes outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_glitch();
    x2_raw = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) x2_raw = 1'b0;
      step();
      n_cmp++;
      if (x2 !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL glitch: cycle %0d x2=%0b busy=%0b expected 0 0", i, x2, busy);
      end
    end
  endtask

  task automatic test_simultaneous();
    int   base;
    int   e;
    logic exp_busy;
    x1_raw = 1'b1;
    x2_raw = 1'b1;
    base = int'(cyc) + 1;
    exp_q.push_back({32'(base + 7), 1'b1, 1'b0});
    exp_q.push_back({32'(base + 11), 1'b1, 1'b1});
    for (int i = 0; i < 16; i++) begin
      step();
      e = int'(cyc) - base;
      exp_busy = (e >= 7 && e <= 9) || (e >= 11 && e <= 13);
      n_cmp++;
      if (conflict !== (e == 7)) begin
        n_err++;
        $display("FAIL simul_conflict: edge %0d conflict=%0b expected %0b", e, conflict, (e == 7));
      end
      n_cmp++;
      if (busy !== exp_busy) begin
        n_err++;
        $display("FAIL simul_busy: edge %0d busy=%0b expected %0b", e, busy, exp_busy);
      end
      n_cmp++;
      if (x2 !== (e >= 11)) begin
        n_err++;
        $display("FAIL simul_x2: edge %0d x2=%0b expected %0b", e, x2, (e >= 11));
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL simul_missing: %0d changes outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_from_ones();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({x1, x2, busy, conflict} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ones: got %4b expected 0000", {x1, x2, busy, conflict});
    end
    x1_raw = 1'b0;
    x2_raw = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({x1, x2, busy} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_ones_hold: cycle %0d got %3b expected 000", i, {x1, x2, busy});
      end
    end
  endtask

  task automatic test_withdrawal();
    int   base;
    int   e;
    logic exp_busy;
    x1_raw = 1'b1;
    base = int'(cyc) + 1;
    exp_q.push_back({32'(base + 7), 1'b1, 1'b0});
    for (int i = 0; i < 17; i++) begin
      step();
      e = int'(cyc) - base;
      if (e == 0) x2_raw = 1'b1;
      if (e == 7) x2_raw = 1'b0;
      exp_busy = (e >= 7 && e <= 9);
      n_cmp++;
      if (x2 !== 1'b0) begin
        n_err++;
        $display("FAIL withdraw_x2: edge %0d x2=%0b expected 0", e, x2);
      end
      n_cmp++;
      if (busy !== exp_busy) begin
        n_err++;
        $display("FAIL withdraw_busy: edge %0d busy=%0b expected %0b", e, busy, exp_busy);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL withdraw_missing: %0d changes outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_settle();
    int base;
    int e;
    x1_raw = 1'b0;
    base = int'(cyc) + 1;
    exp_q.push_back({32'(base + 7), 1'b0, 1'b0});
    for (int i = 0; i < 12; i++) step();
    x1_raw = 1'b1;
    base = int'(cyc) + 1;
    exp_q.push_back({32'(base + 7), 1'b1, 1'b0});
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({x1, busy, conflict} !== 3'b000) begin
      n_err++;
      $display("FAIL midsettle_reset: got x1/busy/conflict=%3b expected 000", {x1, busy, conflict});
    end
    step();
    rst = 1'b0;
    base = int'(cyc) + 1;
    exp_q.push_back({32'(base + 7), 1'b1, 1'b0});
    for (int i = 0; i < 10; i++) begin
      step();
      e = int'(cyc) - base;
      n_cmp++;
      if (x1 !== (e >= 7) || busy !== (e >= 7)) begin
        n_err++;
        $display("FAIL midsettle_rerise: edge %0d x1=%0b busy=%0b expected %0b", e, x1, busy, (e >= 7));
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL midsettle_missing: %0d changes outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_change();
    test_glitch();
    test_simultaneous();
    test_reset_from_ones();
    test_withdrawal();
    test_reset_mid_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
